// File: rtl/csa_pkg.sv
// Shared constants for the carry-select accumulator: state encoding, group layout and the
// beat-count limit.
package csa_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  localparam int unsigned NUM_GRP = 5;
  localparam int unsigned GRP0_W  = 2;
  localparam int unsigned GRP1_W  = 3;
  localparam int unsigned GRP2_W  = 3;
  localparam int unsigned GRP3_W  = 4;
  localparam int unsigned GRP4_W  = 4;

  function automatic int unsigned grp_w(int unsigned g);
    case (g)
      0:       return GRP0_W;
      1:       return GRP1_W;
      2:       return GRP2_W;
      3:       return GRP3_W;
      default: return GRP4_W;
    endcase
  endfunction

  function automatic int unsigned grp_lsb(int unsigned g);
    int unsigned lsb;
    lsb = 0;
    for (int unsigned i = 0; i < g; i++) lsb += grp_w(i);
    return lsb;
  endfunction

  function automatic int unsigned count_max(int unsigned cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

endpackage

// File: rtl/csa_group.sv
// One carry-select group: two ripple rows precomputed for carry-in 0 and 1, then
// selected by the real group carry-in.
module csa_group #(
  parameter int unsigned GW = 4
) (
  input  logic [GW-1:0] a,
  input  logic [GW-1:0] b,
  input  logic          cin,
  output logic [GW-1:0] sum,
  output logic          cout
);

  logic [GW-1:0] s0, s1;
  logic          c0, c1;

  always_comb begin
    s0 = '0;
    s1 = '0;
    c0 = 1'b0;
    c1 = 1'b1;
    for (int i = 0; i < int'(GW); i++) begin
      s0[i] = a[i] ^ b[i] ^ c0;
      c0    = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
      s1[i] = a[i] ^ b[i] ^ c1;
      c1    = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
    end
    sum  = cin ? s1 : s0;
    cout = cin ? c1 : c0;
  end

endmodule

// File: rtl/csa_accum.sv
// Streaming burst accumulator: sums operands through a 2/3/3/4/4 carry-select adder and
// presents total, sticky carry-out and beat count. Group layout is fixed for WIDTH=16.
module csa_accum
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_ovf,
  output logic [COUNT_W-1:0] out_cnt
);

  localparam logic [COUNT_W-1:0] CntMax = COUNT_W'(count_max(COUNT_W));
  localparam logic [COUNT_W-1:0] CntOne = COUNT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]   sum_nxt;
  logic [NUM_GRP:0]   carry;
  logic [COUNT_W-1:0] cnt_inc;
  logic               accept;

  assign carry[0] = 1'b0;

  for (genvar g = 0; g < int'(NUM_GRP); g++) begin : g_grp
    localparam int unsigned GW  = grp_w(g);
    localparam int unsigned LSB = grp_lsb(g);
    csa_group #(
      .GW(GW)
    ) u_grp (
      .a    (acc_q[LSB+:GW]),
      .b    (in_data[LSB+:GW]),
      .cin  (carry[g]),
      .sum  (sum_nxt[LSB+:GW]),
      .cout (carry[g+1])
    );
  end

  // Held low during reset even though the state register already reads ACC.
  assign in_ready  = (state_q == ST_ACC) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_q + CntOne;

  assign out_sum = acc_q;
  assign out_ovf = ovf_q;
  assign out_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACC: begin
        if (accept) begin
          acc_d = sum_nxt;
          ovf_d = ovf_q | carry[NUM_GRP];
          cnt_d = cnt_inc;
          if (in_last || (cnt_inc == CntMax)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_ACC;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
